hazard_ctrl: RTL
================

// Module: hazard_ctrl
// PURPOSE
//  Pipeline controller for the 5-stage core (F/D/E/M/W).
//  Drives forwarding selects for the execute-stage ALU operands.
//  Drives stall and flush enables for the F/D, D/E, E/M and M/W pipeline registers.
//  Resolves load-use, branch/jump and multi-cycle data-memory hazards; the mem-wait sequencing is an FSM.
// PARAMETERS
//  REG_ADDR_WIDTH  5   register index width (Rs*/Rd*)
//  MAX_WAIT        15  max data-mem wait cycles before MemErr
//  CNT_WIDTH       32  perf counter width (PERF_CNT_EN only)
// PORTS
//  clk         in   1   clock
//  rst         in   1   reset: synchronous, active-high
//  Rs1D/Rs2D   in   5   source regs of instr in D
//  Rs1E/Rs2E   in   5   source regs of instr in E
//  RdE/RdM/RdW in   5   dest regs in E/M/W
//  RegWriteM   in   1   M-stage instr writes reg file
//  RegWriteW   in   1   W-stage instr writes reg file
//  LoadE       in   1   E-stage instr is a load (ResultSrcE==01)
//  PCSrcE      in   1   branch taken / jump in E
//  MemReqM     in   1   M-stage instr accesses data mem
//  MemReadyM   in   1   data mem completes access this cycle
//  ForwardAE   out  2   ALU op1 select: 00 RD1E, 01 ResultW, 10 ALUResultM
//  ForwardBE   out  2   ALU op2 select, same encoding
//  StallF, StallD, StallE, StallM  out 1 each  hold the stage register
//  FlushD, FlushE, FlushW          out 1 each  load bubble (all ctrl = 0)
//  MemErr      out  1   sticky: wait exceeded MAX_WAIT
//  StallCnt    out  CNT_WIDTH  stall-cycle count
//  FlushCnt    out  CNT_WIDTH  flush-event count
// BEHAVIOUR
//  Forwarding (comb.), per operand X in {1,2}:
//   - 10 if RegWriteM && RdM!=0 && RdM==RsXE
//   - else 01 if RegWriteW && RdW!=0 && RdW==RsXE
//   - else 00. M has priority over W.
//  lwStall = LoadE && RdE!=0 && (RdE==Rs1D || RdE==Rs2D) && !PCSrcE.
//   A taken branch overrides a load-use on the wrong path.
//  FSM states RUN, MEM_WAIT; registered; reset -> RUN.
//  RUN:
//   - StallF=StallD=lwStall; FlushE=lwStall|PCSrcE; FlushD=PCSrcE
//   - StallE=StallM=FlushW=0
//   - MemReqM && !MemReadyM -> MEM_WAIT. The same cycle already asserts the MEM_WAIT outputs (Mealy).
//  MEM_WAIT:
//   - StallF=StallD=StallE=StallM=1; FlushW=1; FlushD=FlushE=0
//   - Branch/load-use are deferred because E/D are held; inputs stay stable.
//   - MemReadyM -> RUN. The release cycle uses RUN equations.
//  Wait counter (4b min, clog2(MAX_WAIT+1)):
//   - cleared on entry; +1 per MEM_WAIT cycle
//   - at MAX_WAIT: MemErr<=1 (sticky until rst), FSM -> RUN
//  Reset, also mid-MEM_WAIT: state RUN, wait cnt 0, MemErr 0, counters 0.
//   During rst all stall/flush outputs are 0 and ForwardAE/BE=00.
//  Rd==x0 never forwards or stalls.
// CONFIGURATION
//  PERF_CNT_EN defined:
//   - StallCnt +1 each cycle any Stall* =1
//   - FlushCnt +1 each cycle FlushD|FlushE =1
//   - both wrap at 2^CNT_WIDTH
//  PERF_CNT_EN undefined: StallCnt=FlushCnt=0 constant; no counter flops.
// TESTING
//  RdM=5, RegWriteM=1, Rs1E=5; RdW=5, RegWriteW=1 -> ForwardAE=10.
//   Then RegWriteM=0 -> ForwardAE=01.
//  LoadE=1, RdE=3, Rs2D=3, PCSrcE=0 -> StallF=StallD=FlushE=1 for 1 cycle.
//   Same with PCSrcE=1 -> StallF=0, FlushD=FlushE=1.
//  MemReqM=1, MemReadyM low 3 cycles then high -> Stall{F,D,E,M}=FlushW=1 for 3 cycles.
//   Next cycle all 0; MemErr=0.
//  MemReadyM held 0 with MAX_WAIT=15 -> MemErr=1 after 15 wait cycles; FSM back in RUN.
//   MemErr stays 1 until rst.
//  rst asserted in 2nd MEM_WAIT cycle -> next cycle all outputs 0, state RUN.
//   With PERF_CNT_EN: StallCnt=0.
//  RdM=0, RegWriteM=1, Rs1E=0 -> ForwardAE=00.
//   LoadE=1, RdE=0, Rs1D=0 -> no stall.

Source files
------------

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - 5-stage pipeline hazard controller (optional PERF_CNT_EN perf counters)
module hazard_ctrl #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int MAX_WAIT       = 15,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [REG_ADDR_WIDTH-1:0] Rs1D,
  input  logic [REG_ADDR_WIDTH-1:0] Rs2D,
  input  logic [REG_ADDR_WIDTH-1:0] Rs1E,
  input  logic [REG_ADDR_WIDTH-1:0] Rs2E,
  input  logic [REG_ADDR_WIDTH-1:0] RdE,
  input  logic [REG_ADDR_WIDTH-1:0] RdM,
  input  logic [REG_ADDR_WIDTH-1:0] RdW,
  input  logic                      RegWriteM,
  input  logic                      RegWriteW,
  input  logic                      LoadE,
  input  logic                      PCSrcE,
  input  logic                      MemReqM,
  input  logic                      MemReadyM,
  output logic [1:0]                ForwardAE,
  output logic [1:0]                ForwardBE,
  output logic                      StallF,
  output logic                      StallD,
  output logic                      StallE,
  output logic                      StallM,
  output logic                      FlushD,
  output logic                      FlushE,
  output logic                      FlushW,
  output logic                      MemErr,
  output logic [CNT_WIDTH-1:0]      StallCnt,
  output logic [CNT_WIDTH-1:0]      FlushCnt
);

  localparam int WCW = ($clog2(MAX_WAIT + 1) < 4) ? 4 : $clog2(MAX_WAIT + 1);

  typedef enum logic {RUN, MEM_WAIT} state_t;

  state_t         state, state_nxt;
  logic [WCW-1:0] wait_cnt;
  logic           mem_err;
  logic           lw_stall;
  logic           wait_done;
  logic           hold;

  // Forwarding select: M-stage result wins over W-stage; x0 never forwards.
  function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_WIDTH-1:0] rs);
    if (RegWriteM && (RdM != '0) && (RdM == rs))      return 2'b10;
    else if (RegWriteW && (RdW != '0) && (RdW == rs)) return 2'b01;
    else                                              return 2'b00;
  endfunction

  // Operand forwarding selects, forced to RD1E/RD2E while in reset.
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (!rst) begin
      ForwardAE = fwd_sel(Rs1E);
      ForwardBE = fwd_sel(Rs2E);
    end
  end

  assign lw_stall  = LoadE && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D)) && !PCSrcE;
  assign wait_done = (wait_cnt == WCW'(MAX_WAIT - 1));

  // Next state and stall/flush outputs; the wait is entered Mealy-style so the
  // requesting cycle already freezes the pipe, and the release cycle runs normally.
  always_comb begin
    state_nxt = state;
    hold      = 1'b0;
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushW    = 1'b0;
    if (!rst) begin
      case (state)
        RUN: begin
          if (MemReqM && !MemReadyM) begin
            state_nxt = MEM_WAIT;
            hold      = 1'b1;
          end
        end
        MEM_WAIT: begin
          if (MemReadyM) begin
            state_nxt = RUN;
          end else begin
            hold = 1'b1;
            if (wait_done) state_nxt = RUN;
          end
        end
        default: state_nxt = RUN;
      endcase
      if (hold) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushW = 1'b1;
      end else begin
        StallF = lw_stall;
        StallD = lw_stall;
        FlushE = lw_stall | PCSrcE;
        FlushD = PCSrcE;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  // Wait counter (held at zero outside MEM_WAIT) and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else if (state == RUN) begin
      wait_cnt <= '0;
    end else if (!MemReadyM) begin
      wait_cnt <= wait_cnt + 1'b1;
      if (wait_done) mem_err <= 1'b1;
    end
  end

  assign MemErr = mem_err;

`ifdef PERF_CNT_EN
  // Performance counters: stall cycles and flush cycles, free-running with wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      StallCnt <= '0;
      FlushCnt <= '0;
    end else begin
      if (StallF | StallD | StallE | StallM) StallCnt <= StallCnt + 1'b1;
      if (FlushD | FlushE)                   FlushCnt <= FlushCnt + 1'b1;
    end
  end
`else
  assign StallCnt = '0;
  assign FlushCnt = '0;
`endif

endmodule
